mem_arbiter: RTL and testbench

Arbiter and sequencer that shares one multi-cycle, pipelined main memory between the instruction-cache miss path and the data-cache miss/write path of the pipelined CPU. It grants the memory to one requester at a time. For cache fills it issues the block's word addresses and steers the returned words to the owner, reporting each word index. For write-through stores it performs a single-word write. It sits between the two cache controllers and the main memory; the stall logic uses its `busy` output.

---
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one pipelined main memory between the I-cache fill path and the D-cache fill/write path.
// Fills issue the block's word addresses back to back and steer returned words to the owner.
module mem_arbiter #(
    parameter int unsigned WORDS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_req,
    input  logic [15:0]              i_addr,
    input  logic                     d_req,
    input  logic                     d_wr,
    input  logic [15:0]              d_addr,
    input  logic [15:0]              d_wdata,
    input  logic [15:0]              mem_data_in,
    input  logic                     mem_data_valid,
    output logic                     mem_enable,
    output logic                     mem_wr,
    output logic [15:0]              mem_addr,
    output logic [15:0]              mem_data_out,
    output logic [15:0]              fill_data,
    output logic [$clog2(WORDS)-1:0] fill_word,
    output logic                     i_fill_valid,
    output logic                     d_fill_valid,
    output logic                     i_done,
    output logic                     d_done,
    output logic                     busy
);

    localparam int unsigned WW = $clog2(WORDS);
    localparam logic [WW:0] IssEnd = (WW + 1)'(WORDS);
    localparam logic [WW-1:0] RcvLast = WW'(WORDS - 1);
    localparam logic [15:0] BaseMask = ~16'(2 * WORDS - 1);

    typedef enum logic [1:0] {StIdle, StIFill, StDFill, StDWrite} state_e;

    state_e        state_q;
    logic [WW:0]   iss_q;
    logic [WW-1:0] rcv_q;
    logic [15:0]   base_q;
    logic          last_d_q;

    logic d_pend;
    logic grant_d;
    logic in_fill;
    logic fill_hit;
    logic last_word;

    assign d_pend    = d_req | d_wr;
    // On a tie, D wins unless the previous grant already went to D.
    assign grant_d   = d_pend & (~i_req | ~last_d_q);
    assign in_fill   = (state_q == StIFill) | (state_q == StDFill);
    assign fill_hit  = in_fill & mem_data_valid;
    assign last_word = (rcv_q == RcvLast);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            iss_q    <= '0;
            rcv_q    <= '0;
            base_q   <= '0;
            last_d_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (grant_d) begin
                        last_d_q <= 1'b1;
                        if (d_wr) begin
                            state_q <= StDWrite;
                        end else begin
                            state_q <= StDFill;
                            base_q  <= d_addr & BaseMask;
                            iss_q   <= '0;
                            rcv_q   <= '0;
                        end
                    end else if (i_req) begin
                        last_d_q <= 1'b0;
                        state_q  <= StIFill;
                        base_q   <= i_addr & BaseMask;
                        iss_q    <= '0;
                        rcv_q    <= '0;
                    end
                end
                StIFill, StDFill: begin
                    if (iss_q != IssEnd) begin
                        iss_q <= iss_q + 1'b1;
                    end
                    if (mem_data_valid) begin
                        rcv_q <= rcv_q + 1'b1;
                        if (last_word) begin
                            state_q <= StIdle;
                        end
                    end
                end
                StDWrite: state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        mem_enable   = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_data_out = '0;
        fill_data    = mem_data_in;
        fill_word    = '0;
        i_fill_valid = 1'b0;
        d_fill_valid = 1'b0;
        i_done       = 1'b0;
        d_done       = 1'b0;
        busy         = (state_q != StIdle);

        if (in_fill && (iss_q != IssEnd)) begin
            mem_enable = 1'b1;
            mem_addr   = base_q + 16'({iss_q, 1'b0});
        end

        if (fill_hit) begin
            fill_word    = rcv_q;
            i_fill_valid = (state_q == StIFill);
            d_fill_valid = (state_q == StDFill);
            i_done       = (state_q == StIFill) & last_word;
            d_done       = (state_q == StDFill) & last_word;
        end

        if (state_q == StDWrite) begin
            mem_enable   = 1'b1;
            mem_wr       = 1'b1;
            mem_addr     = d_addr;
            mem_data_out = d_wdata;
            d_done       = 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts every memory access and
// returned word with its cycle; a negedge monitor pops and compares as the DUT produces them.
module tb_mem_arbiter;

    localparam int NW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic [15:0] mem_data_in;
    logic        mem_data_valid;
    logic        mem_enable, mem_wr;
    logic [15:0] mem_addr, mem_data_out, fill_data;
    logic [2:0]  fill_word;
    logic        i_fill_valid, d_fill_valid, i_done, d_done, busy;

    always #5 clk = ~clk;

    mem_arbiter #(.WORDS(NW)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_req          (i_req),
        .i_addr         (i_addr),
        .d_req          (d_req),
        .d_wr           (d_wr),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .mem_data_in    (mem_data_in),
        .mem_data_valid (mem_data_valid),
        .mem_enable     (mem_enable),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_data_out   (mem_data_out),
        .fill_data      (fill_data),
        .fill_word      (fill_word),
        .i_fill_valid   (i_fill_valid),
        .d_fill_valid   (d_fill_valid),
        .i_done         (i_done),
        .d_done         (d_done),
        .busy           (busy)
    );

    typedef struct {int cyc; logic wr; logic [15:0] addr; logic [15:0] data;} acc_t;
    typedef struct {int cyc; logic is_d; int word; logic [15:0] data; logic done;} fill_t;

    acc_t        exp_acc[$];
    fill_t       exp_fill[$];
    logic        done_log[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          busy_end = -1;
    logic        last_d = 1'b0;
    int          mem_lat = 3;
    logic        rv[64];
    logic [15:0] rd[64];
    logic        i_done_seen = 1'b0;
    logic        d_done_seen = 1'b0;
    int          i_words = 0;
    int          d_words = 0;
    logic        auto_on = 1'b0;
    logic        spur = 1'b0;
    int unsigned req_pct = 0;
    int unsigned wr_pct = 0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'h5A3C ^ {a[7:0], a[15:8]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    // Reference: a granted fill occupies WORDS+L cycles, a write one cycle.
    task automatic push_fill(input logic is_d, input logic [15:0] addr);
        logic [15:0] b;
        logic [15:0] a;
        b = addr & ~16'(2 * NW - 1);
        for (int k = 0; k < NW; k++) begin
            a = b + 16'(2 * k);
            exp_acc.push_back('{cyc + 1 + k, 1'b0, a, 16'h0});
            exp_fill.push_back('{cyc + 1 + mem_lat + k, is_d, k, mem_word(a), k == NW - 1});
        end
        busy_end = cyc + NW + mem_lat;
    endtask

    task automatic model_grant();
        if (cyc <= busy_end) return;
        if ((d_req || d_wr) && (!i_req || !last_d)) begin
            last_d = 1'b1;
            if (d_wr) begin
                exp_acc.push_back('{cyc + 1, 1'b1, d_addr, d_wdata});
                busy_end = cyc + 1;
            end else begin
                push_fill(1'b1, d_addr);
            end
        end else if (i_req) begin
            last_d = 1'b0;
            push_fill(1'b0, i_addr);
        end
    endtask

    task automatic check_cycle();
        acc_t  a;
        fill_t e;
        logic  exp_en, exp_fv, exp_busy;
        a = '{0, 1'b0, 16'h0, 16'h0};
        e = '{0, 1'b0, 0, 16'h0, 1'b0};
        exp_busy = (cyc <= busy_end);
        exp_en = (exp_acc.size() > 0) && (exp_acc[0].cyc == cyc);
        exp_fv = (exp_fill.size() > 0) && (exp_fill[0].cyc == cyc);
        if (exp_en) a = exp_acc.pop_front();
        if (exp_fv) e = exp_fill.pop_front();
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("fill_data", 32'(fill_data), 32'(mem_data_in));
        chk("mem_enable", 32'(mem_enable), 32'(exp_en));
        chk("mem_wr", 32'(mem_wr), 32'(a.wr));
        chk("mem_addr", 32'(mem_addr), 32'(a.addr));
        chk("mem_data_out", 32'(mem_data_out), 32'(a.data));
        chk("i_fill_valid", 32'(i_fill_valid), 32'(exp_fv && !e.is_d));
        chk("d_fill_valid", 32'(d_fill_valid), 32'(exp_fv && e.is_d));
        chk("i_done", 32'(i_done), 32'(exp_fv && !e.is_d && e.done));
        chk("d_done", 32'(d_done), 32'((exp_fv && e.is_d && e.done) || (exp_en && a.wr)));
        if (exp_fv) begin
            chk("fill_word", 32'(fill_word), 32'(e.word));
            chk("fill_word_data", 32'(fill_data), 32'(e.data));
        end else if (!exp_busy) begin
            chk("idle_fill_word", 32'(fill_word), 32'h0);
        end
        if (i_done) done_log.push_back(1'b0);
        if (d_done) done_log.push_back(1'b1);
        if (i_fill_valid) i_words++;
        if (d_fill_valid) d_words++;
        i_done_seen = i_done;
        d_done_seen = d_done;
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_acc.delete();
                exp_fill.delete();
                busy_end = cyc;
                last_d = 1'b0;
                for (int i = 0; i < 64; i++) rv[i] = 1'b0;
                i_done_seen = 1'b0;
                d_done_seen = 1'b0;
            end else begin
                check_cycle();
                model_grant();
                if (mem_enable && !mem_wr) begin
                    rv[(cyc + mem_lat) % 64] = 1'b1;
                    rd[(cyc + mem_lat) % 64] = mem_word(mem_addr);
                end
            end
        end
    endtask

    // One clock: memory returns and requester behaviour, driven 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        mem_data_valid = rv[cyc % 64];
        mem_data_in = rv[cyc % 64] ? rd[cyc % 64] : 16'($urandom);
        rv[cyc % 64] = 1'b0;
        if (spur) begin
            mem_data_valid = 1'b1;
            mem_data_in = 16'hDEAD;
        end
        if (i_req && i_done_seen) begin
            i_req = 1'b0;
        end else if (!i_req && auto_on && $urandom_range(99) < req_pct) begin
            i_req = 1'b1;
            i_addr = 16'($urandom);
        end
        if ((d_req || d_wr) && d_done_seen) begin
            d_req = 1'b0;
            d_wr = 1'b0;
        end else if (!d_req && !d_wr && auto_on && $urandom_range(99) < req_pct) begin
            if ($urandom_range(99) < wr_pct) d_wr = 1'b1;
            else d_req = 1'b1;
            d_addr = 16'($urandom);
            d_wdata = 16'($urandom);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((i_req || d_req || d_wr || cyc <= busy_end) && t < 2000) begin
            tick();
            t++;
        end
        chk("requests_retired", 32'(i_req | d_req | d_wr), 32'h0);
        tick();
    endtask

    initial begin
        logic tie_exp[4];
        int   n;
        int   t;
        tie_exp = '{1'b1, 1'b0, 1'b1, 1'b0};
        rst = 1'b1;
        {i_req, d_req, d_wr} = 3'b000;
        i_addr = 16'h0;
        d_addr = 16'h0;
        d_wdata = 16'h0;
        mem_data_in = 16'h0;
        mem_data_valid = 1'b0;
        for (int i = 0; i < 64; i++) rv[i] = 1'b0;
        fork
            monitor();
        join_none
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Tie fairness straight after reset: both sides held and re-raised.
        i_req = 1'b1;
        i_addr = 16'h2468;
        d_req = 1'b1;
        d_addr = 16'h8ACE;
        auto_on = 1'b1;
        req_pct = 100;
        wr_pct = 0;
        t = 0;
        while (done_log.size() < 4 && t < 400) begin
            tick();
            t++;
        end
        auto_on = 1'b0;
        wait_idle();
        chk("tie_grants", 32'(done_log.size() >= 4), 32'h1);
        for (int k = 0; k < 4 && k < done_log.size(); k++) begin
            chk($sformatf("tie_order_%0d", k), 32'(done_log[k]), 32'(tie_exp[k]));
        end

        // Isolated I fill at L=4.
        mem_lat = 4;
        i_req = 1'b1;
        i_addr = 16'h1234;
        wait_idle();

        // Isolated write.
        d_wr = 1'b1;
        d_addr = 16'h0040;
        d_wdata = 16'hBEEF;
        wait_idle();

        // Write raised while an I fill is returning word 3.
        i_req = 1'b1;
        i_addr = 16'(16'hC000 | $urandom_range(16'h0FFF));
        n = i_words;
        t = 0;
        while (i_words < n + 4 && t < 100) begin
            tick();
            t++;
        end
        d_wr = 1'b1;
        d_addr = 16'h7F12;
        d_wdata = 16'h55AA;
        wait_idle();

        // Spurious memory return while idle, then a normal fill.
        spur = 1'b1;
        tick();
        spur = 1'b0;
        tick();
        d_req = 1'b1;
        d_addr = 16'h3A5F;
        wait_idle();

        // Reset after three D words, then the same fill again from word 0.
        d_req = 1'b1;
        d_addr = 16'h9E37;
        n = d_words;
        t = 0;
        while (d_words < n + 3 && t < 100) begin
            tick();
            t++;
        end
        rst = 1'b1;
        d_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        d_req = 1'b1;
        wait_idle();

        // Random traffic at two memory latencies.
        for (int p = 0; p < 2; p++) begin
            mem_lat = (p == 0) ? 2 : 7;
            auto_on = 1'b1;
            req_pct = 20;
            wr_pct = 40;
            repeat (1500) tick();
            auto_on = 1'b0;
            wait_idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
